// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_seq (and package rvcpu)
// Purpose  : Iterative shift-and-add multiplier sequencer. Produces the low
//            Width bits of req_a * req_b by issuing one ADD per cycle to the
//            shared execute-stage ALU. Operand shifting and iteration control
//            are local; the ALU only performs the accumulate.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            req_valid/ready   - request handshake, operands req_a / req_b
//            flush             - abort in-flight operation, drop pending result
//            resp_valid/ready  - response handshake, result on resp_data
//            alu_own           - this block drives the shared ALU this cycle
//            alu_op/a/b        - ALU operation and operands (op is always ADD)
//            alu_res           - combinational ALU result
// Revision : 1.0 - initial release
// ============================================================================

package rvcpu;
  typedef logic [3:0] alu_op_t;
  localparam alu_op_t ALU_ADD = 4'b0000;
endpackage

module alu_mul_seq #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [Width-1:0] req_a,
  input  logic [Width-1:0] req_b,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [Width-1:0] resp_data,
  output logic             alu_own,
  output rvcpu::alu_op_t   alu_op,
  output logic [Width-1:0] alu_a,
  output logic [Width-1:0] alu_b,
  input  logic [Width-1:0] alu_res
);

  localparam int CNT_W = $clog2(Width);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Width - 1);

  generate
    if (Width < 2) begin : g_width_check
      $error("alu_mul_seq: Width must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [Width-1:0] acc, acc_nx;
  logic [Width-1:0] mcand, mcand_nx;
  logic [Width-1:0] mplier, mplier_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [Width-1:0] mplier_shr;

  // Multiplier after this cycle's shift; when it is zero no further partial
  // products remain, which gives the early-out on small multipliers.
  assign mplier_shr = mplier >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      acc    <= acc_nx;
      mcand  <= mcand_nx;
      mplier <= mplier_nx;
      cnt    <= cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    acc_nx     = acc;
    mcand_nx   = mcand;
    mplier_nx  = mplier;
    cnt_nx     = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    alu_own    = 1'b0;
    alu_op     = rvcpu::ALU_ADD;
    alu_a      = '0;
    alu_b      = '0;

    case (state)
      IDLE: begin
        // A request coinciding with flush is refused outright.
        req_ready = !flush;
        if (req_valid && !flush) begin
          acc_nx    = '0;
          mcand_nx  = req_a;
          mplier_nx = req_b;
          cnt_nx    = '0;
          state_nx  = CALC;
        end
      end
      CALC: begin
        // alu_own decodes only the registered state, so the execute-stage
        // operand mux select is stable from the start of the cycle.
        alu_own   = 1'b1;
        alu_a     = acc;
        alu_b     = mcand;
        if (mplier[0]) begin
          acc_nx = alu_res;
        end
        mcand_nx  = mcand << 1;
        mplier_nx = mplier_shr;
        cnt_nx    = cnt + CNT_W'(1);
        if ((mplier_shr == '0) || (cnt == CNT_LAST)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_data  = acc;
        if (resp_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    // Flush overrides every state; datapath registers are left as computed.
    if (flush) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_mul_seq.md
# alu_mul_seq

Iterative shift-and-add multiplier sequencer. It computes the low `Width` bits of `a * b` by driving the shared `alu` instance with one ADD per cycle. Operand shifting and iteration control are done locally. It sits beside the execute stage: while it is busy it owns the ALU operand/op inputs, and the execute-stage mux selects it via `alu_own`.

## Interface
- `Width`, 32, operand/result width; must be ≥2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: multiply request valid.
- `req_ready` output 1: block can accept a request.
- `req_a` input Width: multiplicand.
- `req_b` input Width: multiplier.
- `flush` input 1: abort any operation in flight and drop any pending result.
- `resp_valid` output 1: `resp_data` valid.
- `resp_ready` input 1: consumer accepts the result.
- `resp_data` output Width: low `Width` bits of `req_a * req_b`.
- `alu_own` output 1: block is driving the ALU this cycle.
- `alu_op` output `rvcpu::alu_op_t`: ALU op; always ADD (4'b0000).
- `alu_a` output Width: ALU operand a.
- `alu_b` output Width: ALU operand b.
- `alu_res` input Width: ALU result, combinational from `alu_op`/`alu_a`/`alu_b`.

## Operation
**States:** IDLE, CALC, DONE.

**Internal registers:**
- `acc`: accumulator, Width bits.
- `mcand`: shifting multiplicand, Width bits.
- `mplier`: shifting multiplier, Width bits.
- `cnt`: iteration counter, $clog2(Width) bits.

**IDLE**
- `req_ready=1`.
- On `req_valid && req_ready`: `acc<=0`, `mcand<=req_a`, `mplier<=req_b`, `cnt<=0`, go to CALC.

**CALC** (`alu_own=1`, `alu_a=acc`, `alu_b=mcand`), each cycle:
- If `mplier[0]`: `acc<=alu_res`; otherwise `acc` holds.
- `mcand<=mcand<<1`, `mplier<=mplier>>1`, `cnt<=cnt+1`.
- Go to DONE when `(mplier>>1)==0` or `cnt==Width-1`; otherwise stay in CALC.

**DONE**
- `resp_valid=1`, `resp_data=acc`, held stable until `resp_ready`.
- On `resp_ready`: go to IDLE.

**Outputs outside CALC:** `alu_own=0`, `alu_op=ADD`, `alu_a=0`, `alu_b=0`.

**Arithmetic:**
- All additions wrap modulo 2^Width; overflow is discarded.
- Result is identical for signed and unsigned interpretations (low half only).

**`flush`:**
- Highest priority in every state: next state IDLE and `cnt<=0`.
- `acc`, `mcand` and `mplier` contents are don't-care after a flush.
- A `req_valid` in the same cycle as `flush` is not accepted; `req_ready` is 0 when `flush=1`.

**Reset:**
- State IDLE; `acc`, `mcand`, `mplier`, `cnt` = 0.
- Outputs after reset: `req_ready=1`, `resp_valid=0`, `resp_data=0`, `alu_own=0`, `alu_op=ADD`, `alu_a=0`, `alu_b=0`.
- Reset asserted mid-CALC or mid-DONE returns to IDLE immediately (asynchronous), and the result is lost.

## Timing
**Latency:**
- N = number of CALC cycles = max(1, index of highest set bit of `req_b` + 1).
- `b==0` takes exactly 1 CALC cycle and yields `resp_data=0`.
- Request accepted at edge E0; CALC occupies cycles E0..E0+N; `resp_valid` rises after edge E0+N.
- Worst case N = Width (`req_b[Width-1]=1`).

**Throughput:**
- At most one operation in flight.
- `req_ready=0` in CALC and DONE, so a new request can be accepted at the earliest in the cycle after the response handshake.

**ALU path:**
- The ALU path is combinational within one cycle: `alu_res` must settle within the same cycle as `alu_a`/`alu_b`.
- `alu_own` is a registered-state decode (state==CALC), so the execute-stage mux select is glitch-free at cycle start.

**Backpressure:** DONE may hold indefinitely. `resp_data` must not change while `resp_valid=1`.

## Test plan
- Reset then idle -> `req_ready=1`, `resp_valid=0`, `alu_own=0`, `alu_a=alu_b=0`.
- `a=7, b=6` -> `alu_own` high for exactly 3 cycles; then `resp_valid=1`, `resp_data=42`.
- `a=0x1234, b=0` -> 1 CALC cycle; `resp_data=0`.
- `a=0xFFFFFFFF, b=0xFFFFFFFF` -> 32 CALC cycles; `resp_data=0x00000001`.
- `a=-3 (0xFFFFFFFD), b=5` -> `resp_data=0xFFFFFFF1`.
- Backpressure: hold `resp_ready=0` for 10 cycles with `a=3, b=4` -> `resp_data=12` stable throughout, `req_ready=0` throughout; the following request is accepted only after the handshake.
- Flush at the 5th CALC cycle of `b=0x80000000` -> IDLE next cycle, no `resp_valid`.
- Async `rst` pulse mid-CALC -> IDLE immediately, no `resp_valid`.
- Next request `a=2, b=3` after the flush/reset cases -> `resp_data=6`.
